// File: rtl/fm_lfo.sv
// Low-frequency oscillator shared by all FM operators: produces the tremolo
// attenuation for the envelope generator and the vibrato fnum offset for the phase generator.
module fm_lfo (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sample_tick,
    input  logic       lfo_reset,
    input  logic       dam,
    input  logic       dvb,
    input  logic [2:0] fnum_hi,
    output logic [5:0] am_val,
    output logic [2:0] vib_pos,
    output logic [3:0] vib_delta
);

    logic [9:0] sample_cnt_r;
    logic [7:0] am_pos_r;
    logic [2:0] vib_pos_r;
    logic [5:0] am_val_r;

    logic [7:0] tri_val_s;
    logic [5:0] am_next_s;
    logic [2:0] vib_f_s;
    logic [2:0] vib_mag_s;
    logic       vib_neg_s;

    // Sample counter and the AM / vibrato phase counters; lfo_reset beats a same-edge tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_cnt_r <= 10'd0;
            am_pos_r     <= 8'd0;
            vib_pos_r    <= 3'd0;
        end else if (lfo_reset) begin
            sample_cnt_r <= 10'd0;
            am_pos_r     <= 8'd0;
            vib_pos_r    <= 3'd0;
        end else if (sample_tick) begin
            sample_cnt_r <= sample_cnt_r + 10'd1;
            if (sample_cnt_r[5:0] == 6'd63) begin
                am_pos_r <= (am_pos_r == 8'd209) ? 8'd0 : am_pos_r + 8'd1;
            end
            if (sample_cnt_r == 10'd1023) begin
                vib_pos_r <= vib_pos_r + 3'd1;
            end
        end
    end

    // Triangle tremolo shape folded around position 104/105, scaled by depth
    always_comb begin
        tri_val_s = 8'd0;
        am_next_s = 6'd0;
        if (am_pos_r < 8'd105) begin
            tri_val_s = am_pos_r;
        end else begin
            tri_val_s = 8'd209 - am_pos_r;
        end
        if (dam) begin
            am_next_s = 6'(tri_val_s >> 2);
        end else begin
            am_next_s = 6'(tri_val_s >> 4);
        end
    end

    // Tremolo output register, refreshed every clock so dam changes land on the next edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            am_val_r <= 6'd0;
        end else if (lfo_reset) begin
            am_val_r <= 6'd0;
        end else begin
            am_val_r <= am_next_s;
        end
    end

    // Vibrato offset: combinational because fnum_hi changes every operator slot
    always_comb begin
        vib_f_s   = 3'd0;
        vib_mag_s = 3'd0;
        vib_neg_s = 1'b0;
        vib_delta = 4'd0;
        if (dvb) begin
            vib_f_s = fnum_hi;
        end else begin
            vib_f_s = {1'b0, fnum_hi[2:1]};
        end
        case (vib_pos_r)
            3'd1, 3'd3: begin
                vib_mag_s = {1'b0, vib_f_s[2:1]};
                vib_neg_s = 1'b0;
            end
            3'd2: begin
                vib_mag_s = vib_f_s;
                vib_neg_s = 1'b0;
            end
            3'd5, 3'd7: begin
                vib_mag_s = {1'b0, vib_f_s[2:1]};
                vib_neg_s = 1'b1;
            end
            3'd6: begin
                vib_mag_s = vib_f_s;
                vib_neg_s = 1'b1;
            end
            default: begin
                vib_mag_s = 3'd0;
                vib_neg_s = 1'b0;
            end
        endcase
        if (vib_neg_s) begin
            vib_delta = 4'd0 - {1'b0, vib_mag_s};
        end else begin
            vib_delta = {1'b0, vib_mag_s};
        end
    end

    assign am_val  = am_val_r;
    assign vib_pos = vib_pos_r;

endmodule

// File: tb/tb_fm_lfo.sv
// Self-checking bench for fm_lfo: randomized vibrato inputs and tick streams
// checked against an arithmetic model driven by the count of ticks since clear.
module tb_fm_lfo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sample_tick;
    logic       lfo_reset;
    logic       dam;
    logic       dvb;
    logic [2:0] fnum_hi;
    logic [5:0] am_val;
    logic [2:0] vib_pos;
    logic [3:0] vib_delta;

    int n_vec = 0;
    int n_err = 0;
    int n_tk  = 0;

    fm_lfo dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_tick(sample_tick),
        .lfo_reset  (lfo_reset),
        .dam        (dam),
        .dvb        (dvb),
        .fnum_hi    (fnum_hi),
        .am_val     (am_val),
        .vib_pos    (vib_pos),
        .vib_delta  (vib_delta)
    );

    always #5 clk = ~clk;

    // Reference model: everything derives from the number of ticks since clear
    function automatic int m_am_pos(int n);
        return (n / 64) % 210;
    endfunction

    function automatic int m_vib(int n);
        return (n / 1024) % 8;
    endfunction

    function automatic int m_am_val(int pos, int deep);
        int t;
        t = (pos < 105) ? pos : 209 - pos;
        return deep != 0 ? t / 4 : t / 16;
    endfunction

    function automatic int m_delta(int vp, int deep, int fh);
        int mult [8] = '{0, 1, 2, 1, 0, -1, -2, -1};
        int f;
        f = (deep != 0) ? fh : fh / 2;
        return (mult[vp] * f) / 2;
    endfunction

    task automatic lfo_clear();
        @(negedge clk);
        lfo_reset = 1'b1;
        @(negedge clk);
        lfo_reset = 1'b0;
        n_tk = 0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // One pulsed tick followed by model checks and a random zero-latency vibrato probe
    task automatic step_tick();
        int prev;
        logic [5:0] e_am;
        logic [2:0] e_vp;
        logic [3:0] e_d;
        prev = n_tk;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        n_tk++;
        e_vp = 3'(m_vib(n_tk));
        e_am = 6'(m_am_val(m_am_pos(prev), int'(dam)));
        n_vec++;
        if (vib_pos !== e_vp) begin
            n_err++;
            if (n_err <= 20) $display("FAIL tick_vib_pos n=%0d: got %0d, expected %0d", n_tk, vib_pos, e_vp);
        end
        n_vec++;
        if (am_val !== e_am) begin
            n_err++;
            if (n_err <= 20) $display("FAIL tick_am_val n=%0d: got %0d, expected %0d", n_tk, am_val, e_am);
        end
        fnum_hi = 3'($urandom_range(0, 7));
        dvb     = 1'($urandom_range(0, 1));
        #1;
        e_d = 4'(m_delta(m_vib(n_tk), int'(dvb), int'(fnum_hi)));
        n_vec++;
        if (vib_delta !== e_d) begin
            n_err++;
            if (n_err <= 20) $display("FAIL tick_vib_delta n=%0d fnum_hi=%0d dvb=%0d: got %0d, expected %0d",
                                      n_tk, fnum_hi, dvb, vib_delta, e_d);
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b1;
        sample_tick = 1'b0;
        lfo_reset   = 1'b0;
        dam         = 1'b0;
        dvb         = 1'b1;
        fnum_hi     = 3'd7;
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (am_val !== 6'd0) begin n_err++; $display("FAIL reset_am_val: got %0d, expected 0", am_val); end
        n_vec++;
        if (vib_pos !== 3'd0) begin n_err++; $display("FAIL reset_vib_pos: got %0d, expected 0", vib_pos); end
        n_vec++;
        if (vib_delta !== 4'd0) begin n_err++; $display("FAIL reset_vib_delta: got %0d, expected 0", vib_delta); end
        @(negedge clk);
        reset_n = 1'b1;
        n_tk = 0;
    endtask

    task automatic test_am_ramp();
        dam = 1'b1;
        for (int i = 0; i < 64; i++) step_tick();
        settle();
        n_vec++;
        if (am_val !== 6'd0) begin n_err++; $display("FAIL ramp_64_ticks: got %0d, expected 0", am_val); end
        for (int i = 64; i < 6720; i++) step_tick();
        settle();
        n_vec++;
        if (am_val !== 6'd26) begin n_err++; $display("FAIL ramp_peak_dam1: got %0d, expected 26", am_val); end
        dam = 1'b0;
        settle();
        n_vec++;
        if (am_val !== 6'd6) begin n_err++; $display("FAIL ramp_peak_dam0: got %0d, expected 6", am_val); end
    endtask

    task automatic test_am_period();
        logic [5:0] samp [211];
        lfo_clear();
        dam = 1'b1;
        settle();
        samp[0] = am_val;
        for (int k = 1; k <= 210; k++) begin
            for (int j = 0; j < 64; j++) step_tick();
            settle();
            samp[k] = am_val;
            n_vec++;
            if (samp[k] !== 6'(m_am_val(k % 210, 1))) begin
                n_err++;
                if (n_err <= 20) $display("FAIL period_step k=%0d: got %0d, expected %0d", k, samp[k], m_am_val(k % 210, 1));
            end
        end
        n_vec++;
        if (am_val !== 6'd0) begin n_err++; $display("FAIL period_wrap: got %0d, expected 0", am_val); end
        for (int k = 0; k <= 104; k++) begin
            n_vec++;
            if (samp[k] !== samp[209 - k]) begin
                n_err++;
                if (n_err <= 20) $display("FAIL period_symmetry k=%0d: got %0d, expected %0d", k, samp[k], samp[209 - k]);
            end
        end
    endtask

    task automatic test_vibrato();
        lfo_clear();
        dam = 1'($urandom_range(0, 1));
        for (int i = 0; i < 1024; i++) step_tick();
        fnum_hi = 3'd7; dvb = 1'b1; #1;
        n_vec++;
        if (vib_pos !== 3'd1) begin n_err++; $display("FAIL vib_pos_1: got %0d, expected 1", vib_pos); end
        n_vec++;
        if (vib_delta !== 4'd3) begin n_err++; $display("FAIL vib_pos1_deep: got %0d, expected 3", vib_delta); end
        fnum_hi = 3'd1; dvb = 1'b0; #1;
        n_vec++;
        if (vib_delta !== 4'd0) begin n_err++; $display("FAIL vib_small_pos1: got %0d, expected 0", vib_delta); end
        for (int i = 0; i < 1024; i++) step_tick();
        fnum_hi = 3'd7; dvb = 1'b0; #1;
        n_vec++;
        if (vib_delta !== 4'd3) begin n_err++; $display("FAIL vib_pos2_shallow: got %0d, expected 3", vib_delta); end
        fnum_hi = 3'd1; dvb = 1'b0; #1;
        n_vec++;
        if (vib_delta !== 4'd0) begin n_err++; $display("FAIL vib_small_pos2: got %0d, expected 0", vib_delta); end
        for (int i = 0; i < 4096; i++) step_tick();
        fnum_hi = 3'd7; dvb = 1'b1; #1;
        n_vec++;
        if (vib_pos !== 3'd6) begin n_err++; $display("FAIL vib_pos_6: got %0d, expected 6", vib_pos); end
        n_vec++;
        if (vib_delta !== 4'b1001) begin n_err++; $display("FAIL vib_pos6_deep: got %0d, expected 9", vib_delta); end
        fnum_hi = 3'd1; dvb = 1'b0; #1;
        n_vec++;
        if (vib_delta !== 4'd0) begin n_err++; $display("FAIL vib_small_pos6: got %0d, expected 0", vib_delta); end
    endtask

    task automatic test_lfo_reset_vs_tick();
        lfo_clear();
        dam = 1'($urandom_range(0, 1));
        for (int i = 0; i < 3263; i++) step_tick();
        @(negedge clk);
        lfo_reset   = 1'b1;
        sample_tick = 1'b1;
        @(negedge clk);
        lfo_reset   = 1'b0;
        sample_tick = 1'b0;
        n_tk = 0;
        n_vec++;
        if (am_val !== 6'd0) begin n_err++; $display("FAIL clr_am_val: got %0d, expected 0", am_val); end
        n_vec++;
        if (vib_pos !== 3'd0) begin n_err++; $display("FAIL clr_vib_pos: got %0d, expected 0", vib_pos); end
        for (int i = 0; i < 1024; i++) step_tick();
        n_vec++;
        if (vib_pos !== 3'd1) begin n_err++; $display("FAIL clr_tick_discarded: got %0d, expected 1", vib_pos); end
    endtask

    task automatic test_stress_async_reset();
        int prev;
        logic [5:0] e_am;
        lfo_clear();
        dam = 1'b1;
        @(negedge clk);
        sample_tick = 1'b1;
        for (int i = 0; i < 7700; i++) begin
            prev = n_tk;
            @(negedge clk);
            n_tk++;
            e_am = 6'(m_am_val(m_am_pos(prev), 1));
            n_vec++;
            if (am_val !== e_am || vib_pos !== 3'(m_vib(n_tk))) begin
                n_err++;
                if (n_err <= 20) $display("FAIL stress n=%0d: got am %0d vib %0d, expected am %0d vib %0d",
                                          n_tk, am_val, vib_pos, e_am, m_vib(n_tk));
            end
        end
        sample_tick = 1'b0;
        settle();
        n_vec++;
        if (am_val !== 6'd22) begin n_err++; $display("FAIL pre_reset_am_val: got %0d, expected 22", am_val); end
        n_vec++;
        if (vib_pos !== 3'd7) begin n_err++; $display("FAIL pre_reset_vib_pos: got %0d, expected 7", vib_pos); end
        #2;
        fnum_hi = 3'd7;
        dvb     = 1'b1;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (am_val !== 6'd0) begin n_err++; $display("FAIL async_am_val: got %0d, expected 0", am_val); end
        n_vec++;
        if (vib_pos !== 3'd0) begin n_err++; $display("FAIL async_vib_pos: got %0d, expected 0", vib_pos); end
        n_vec++;
        if (vib_delta !== 4'd0) begin n_err++; $display("FAIL async_vib_delta: got %0d, expected 0", vib_delta); end
        @(negedge clk);
        reset_n     = 1'b1;
        n_tk        = 0;
        sample_tick = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            n_tk++;
            n_vec++;
            if (vib_pos !== 3'(m_vib(n_tk))) begin
                n_err++;
                if (n_err <= 20) $display("FAIL post_reset_vib n=%0d: got %0d, expected %0d", n_tk, vib_pos, m_vib(n_tk));
            end
        end
        sample_tick = 1'b0;
        n_vec++;
        if (vib_pos !== 3'd1) begin n_err++; $display("FAIL post_reset_1024: got %0d, expected 1", vib_pos); end
    endtask

    initial begin
        test_reset();
        test_am_ramp();
        test_am_period();
        test_vibrato();
        test_lfo_reset_vs_tick();
        test_stress_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
